// File: rtl/paint_pkg.sv
// Shared types and constants for the brush painter write path.
// The erase code must stay in step with the colour table used by the pixel store.
package paint_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STAMP = 2'd1,
      CLEAR = 2'd2
   } painter_state_t;

   localparam int         CANVAS_MAX = 127;
   localparam logic [2:0] ERASE_CODE = 3'b000;

   function automatic logic [1:0] clamp_radius(input logic [1:0] size, input int max_r);
      return (int'(size) > max_r) ? 2'(max_r) : size;
   endfunction

endpackage

// File: rtl/brush_offset_gen.sv
// Raster-order (dx,dy) walker over the square -r..r x -r..r; dy is the outer loop.
// start loads the top-left corner, advance steps one offset, last flags (+r,+r).
module brush_offset_gen #(
   parameter int OFS_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              r,
   input  logic                    start,
   input  logic                    advance,
   output logic signed [OFS_W-1:0] dx,
   output logic signed [OFS_W-1:0] dy,
   output logic                    last
);

   localparam logic signed [OFS_W-1:0] ONE = 1;

   logic signed [OFS_W-1:0] r_dx;
   logic signed [OFS_W-1:0] r_dy;
   logic signed [OFS_W-1:0] w_rpos;
   logic signed [OFS_W-1:0] w_rneg;

   assign w_rpos = $signed({{(OFS_W-2){1'b0}}, r});
   assign w_rneg = -w_rpos;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (start) begin
         r_dx <= w_rneg;
         r_dy <= w_rneg;
      end else if (advance) begin
         if (r_dx == w_rpos) begin
            r_dx <= w_rneg;
            r_dy <= r_dy + ONE;
         end else begin
            r_dx <= r_dx + ONE;
         end
      end
   end

   assign dx   = r_dx;
   assign dy   = r_dy;
   assign last = (r_dx == w_rpos) && (r_dy == w_rpos);

endmodule

// File: rtl/brush_painter.sv
// Expands stamp/clear commands into single-pixel writes for the pixel store,
// one write per wr_slot strobe; clipped stamp offsets are skipped in one cycle each.
module brush_painter
   import paint_pkg::*;
#(
   parameter int         CANVAS_BITS = 7,
   parameter int         MAX_RADIUS  = 3,
   parameter logic [2:0] ERASE_COLOR = ERASE_CODE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_clear,
   input  logic [7:0] cmd_x,
   input  logic [7:0] cmd_y,
   input  logic [2:0] cmd_color,
   input  logic [1:0] cmd_size,
   input  logic       wr_slot,
   output logic       brush,
   output logic [7:0] wx,
   output logic [7:0] wy,
   output logic [2:0] newColor,
   output logic       busy
);

   localparam int ADDR_W = 2 * CANVAS_BITS;
   localparam int PIX_W  = 9;
   localparam int OFS_W  = 4;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

   painter_state_t    r_state;
   logic [7:0]        r_cx;
   logic [7:0]        r_cy;
   logic [2:0]        r_color;
   logic [1:0]        r_radius;
   logic [ADDR_W-1:0] r_addr;

   logic                    w_accept;
   logic [1:0]              w_radius;
   logic signed [OFS_W-1:0] w_dx;
   logic signed [OFS_W-1:0] w_dy;
   logic                    w_last;
   logic signed [PIX_W-1:0] w_px;
   logic signed [PIX_W-1:0] w_py;
   logic                    w_in_range;
   logic                    w_stamp_wr;
   logic                    w_adv;

   assign cmd_ready = (r_state == IDLE);
   assign busy      = ~cmd_ready;
   assign w_accept  = cmd_valid && cmd_ready;

   // The walker sees the fresh clamped size on the accept edge, the latched one afterwards.
   assign w_radius = (r_state == IDLE) ? clamp_radius(cmd_size, MAX_RADIUS) : r_radius;

   brush_offset_gen #(
      .OFS_W(OFS_W)
   ) u_offset_gen (
      .clk    (clk),
      .reset  (reset),
      .r      (w_radius),
      .start  (w_accept && !cmd_clear),
      .advance((r_state == STAMP) && w_adv),
      .dx     (w_dx),
      .dy     (w_dy),
      .last   (w_last)
   );

   assign w_px = $signed({1'b0, r_cx}) + $signed({{(PIX_W-OFS_W){w_dx[OFS_W-1]}}, w_dx});
   assign w_py = $signed({1'b0, r_cy}) + $signed({{(PIX_W-OFS_W){w_dy[OFS_W-1]}}, w_dy});

   // Negative or >= canvas side both show up as a set bit above the coordinate field.
   assign w_in_range = (w_px[PIX_W-1:CANVAS_BITS] == '0) && (w_py[PIX_W-1:CANVAS_BITS] == '0);
   assign w_stamp_wr = (r_state == STAMP) && w_in_range;

   always_comb begin
      w_adv = 1'b0;
      case (r_state)
         STAMP:   w_adv = w_in_range ? wr_slot : 1'b1;
         CLEAR:   w_adv = wr_slot;
         default: w_adv = 1'b0;
      endcase
   end

   always_comb begin
      brush    = 1'b0;
      wx       = '0;
      wy       = '0;
      newColor = '0;
      if (w_stamp_wr) begin
         brush    = 1'b1;
         wx       = 8'(w_px[CANVAS_BITS-1:0]);
         wy       = 8'(w_py[CANVAS_BITS-1:0]);
         newColor = r_color;
      end else if (r_state == CLEAR) begin
         brush    = 1'b1;
         wx       = 8'(r_addr[CANVAS_BITS-1:0]);
         wy       = 8'(r_addr[ADDR_W-1:CANVAS_BITS]);
         newColor = ERASE_COLOR;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cx     <= '0;
         r_cy     <= '0;
         r_color  <= '0;
         r_radius <= '0;
         r_addr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cx     <= cmd_x;
                  r_cy     <= cmd_y;
                  r_color  <= cmd_color;
                  r_radius <= w_radius;
                  r_addr   <= '0;
                  r_state  <= cmd_clear ? CLEAR : STAMP;
               end
            end
            STAMP: begin
               if (w_adv && w_last)
                  r_state <= IDLE;
            end
            CLEAR: begin
               if (w_adv) begin
                  r_addr <= r_addr + ADDR_ONE;
                  if (r_addr == ADDR_LAST)
                     r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_brush_painter.sv
// Scoreboard bench for brush_painter: a pixel-list model feeds an expected-write queue,
// and a monitor pops and compares each write the DUT hands to the store.
module tb_brush_painter;

   localparam int BUDGET = 20000;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clear;
   logic [7:0] cmd_x;
   logic [7:0] cmd_y;
   logic [2:0] cmd_color;
   logic [1:0] cmd_size;
   logic       wr_slot;
   logic       brush;
   logic [7:0] wx;
   logic [7:0] wy;
   logic [2:0] newColor;
   logic       busy;

   brush_painter dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_clear(cmd_clear),
      .cmd_x    (cmd_x),
      .cmd_y    (cmd_y),
      .cmd_color(cmd_color),
      .cmd_size (cmd_size),
      .wr_slot  (wr_slot),
      .brush    (brush),
      .wx       (wx),
      .wy       (wy),
      .newColor (newColor),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int c;
   } wr_t;

   wr_t  exp_q[$];
   int   vectors      = 0;
   int   miscompares  = 0;
   int   wr_count     = 0;
   int   brush_cycles = 0;
   int   slot_mode    = 0;
   logic hold_pending = 1'b0;
   logic [18:0] hold_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference model: every in-canvas pixel of the square, row by row.
   task automatic model_stamp(input int cx, input int cy, input int c, input int size);
      int r;
      r = (size > 3) ? 3 : size;
      for (int dy = -r; dy <= r; dy++)
         for (int dx = -r; dx <= r; dx++)
            if (cx + dx >= 0 && cx + dx <= 127 && cy + dy >= 0 && cy + dy <= 127)
               exp_q.push_back('{cx + dx, cy + dy, c});
   endtask

   task automatic model_clear();
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++)
            exp_q.push_back('{x, y, 0});
   endtask

   // wr_slot pattern: 0 = always, 1 = alternating like the store, 2 = random.
   initial begin
      wr_slot = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (slot_mode)
            0:       wr_slot = 1'b1;
            1:       wr_slot = ~wr_slot;
            default: wr_slot = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: a write is consumed on the edge following a negedge with brush && wr_slot.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_pending = 1'b0;
         end else if (brush) begin
            brush_cycles++;
            if (hold_pending)
               check("hold_stable", {13'd0, wx, wy, newColor}, {13'd0, hold_val});
            if (wr_slot) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_write: got (%0d,%0d,%0d), expected none", wx, wy, newColor);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  check("wx", {24'd0, wx}, e.x);
                  check("wy", {24'd0, wy}, e.y);
                  check("color", {29'd0, newColor}, e.c);
               end
               wr_count++;
               hold_pending = 1'b0;
            end else begin
               hold_pending = 1'b1;
               hold_val     = {wx, wy, newColor};
            end
         end else if (hold_pending) begin
            vectors++;
            miscompares++;
            $display("FAIL write_dropped: got brush=0, expected held write %0h", hold_val);
            hold_pending = 1'b0;
         end
      end
   end

   task automatic run_cmd(input bit clr, input int x, input int y, input int c, input int size,
                          input bit hold_valid, output int cycles);
      int n;
      int base;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_cmd", {31'd0, cmd_ready}, 1);
      if (clr) model_clear();
      else     model_stamp(x, y, c, size);
      base         = wr_count;
      cmd_valid    = 1'b1;
      cmd_clear    = clr;
      cmd_x        = x[7:0];
      cmd_y        = y[7:0];
      cmd_color    = c[2:0];
      cmd_size     = size[1:0];
      brush_cycles = 0;
      @(posedge clk);
      #1;
      if (hold_valid) begin
         cmd_clear = 1'b1;
         cmd_x     = ~cmd_x;
         cmd_y     = ~cmd_y;
         cmd_color = 3'b111;
         cmd_size  = 2'd0;
      end else begin
         cmd_valid = 1'b0;
      end
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!cmd_ready && cycles < BUDGET);
      cmd_valid = 1'b0;
      check("done_in_budget", {31'd0, cmd_ready}, 1);
      check("queue_drained", exp_q.size(), 0);
      $display("cmd clear=%0d at (%0d,%0d) colour=%0d size=%0d: %0d writes, %0d cycles",
               clr, x, y, c, size, wr_count - base, cycles);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int base;
      int n;
      int rx, ry, rs, rc, r;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_clear = 1'b0;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_color = '0;
      cmd_size  = '0;
      #1;
      // No clock edge has happened yet: outputs come from the asynchronous reset alone.
      check("rst_brush", {31'd0, brush}, 0);
      check("rst_wx", {24'd0, wx}, 0);
      check("rst_wy", {24'd0, wy}, 0);
      check("rst_color", {29'd0, newColor}, 0);
      check("rst_ready", {31'd0, cmd_ready}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;

      // Single-pixel stamp.
      slot_mode = 0;
      run_cmd(1'b0, 10, 20, 2, 0, 1'b0, cyc);
      check("t2_ready_cycles", cyc, 2);
      check("t2_brush_cycles", brush_cycles, 1);

      // Corner stamp with five clipped offsets.
      base = wr_count;
      run_cmd(1'b0, 0, 0, 5, 1, 1'b0, cyc);
      check("t3_cycles", cyc, 10);
      check("t3_writes", wr_count - base, 4);

      // Reset while idle, mid-cycle.
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("idle_rst_brush", {31'd0, brush}, 0);
      check("idle_rst_ready", {31'd0, cmd_ready}, 1);
      check("idle_rst_busy", {31'd0, busy}, 0);
      @(negedge clk);
      #1 reset = 1'b0;

      // Paced stamp with a different command held on the bus while busy.
      slot_mode = 1;
      base = wr_count;
      run_cmd(1'b0, 64, 64, 6, 2, 1'b1, cyc);
      check("t4_writes", wr_count - base, 25);

      // Fully outside square: every candidate skipped in one cycle.
      slot_mode = 2;
      base = wr_count;
      run_cmd(1'b0, 200, 200, 3, 3, 1'b0, cyc);
      check("outside_writes", wr_count - base, 0);
      check("outside_cycles", cyc, 50);

      // Randomised stamps, many near or past the canvas edges.
      for (int i = 0; i < 14; i++) begin
         rx = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 130);
         ry = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 130);
         rs = $urandom_range(0, 3);
         rc = $urandom_range(0, 7);
         slot_mode = $urandom_range(0, 2);
         run_cmd(1'b0, rx, ry, rc, rs, ($urandom_range(0, 1) == 1), cyc);
         if (slot_mode == 0) begin
            r = rs;
            check("rand_cycles_fullslot", cyc, (2 * r + 1) * (2 * r + 1) + 1);
         end
      end

      // Whole-canvas clear.
      slot_mode = 0;
      base = wr_count;
      run_cmd(1'b1, 0, 0, 7, 3, 1'b0, cyc);
      check("t5_writes", wr_count - base, 16384);
      check("t5_cycles", cyc, 16385);

      // Reset in the middle of a size-3 stamp.
      slot_mode = 0;
      @(negedge clk);
      model_stamp(64, 64, 5, 3);
      base      = wr_count;
      cmd_valid = 1'b1;
      cmd_clear = 1'b0;
      cmd_x     = 8'd64;
      cmd_y     = 8'd64;
      cmd_color = 3'd5;
      cmd_size  = 2'd3;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (wr_count < base + 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_five_writes", {31'd0, wr_count >= base + 5}, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_brush", {31'd0, brush}, 0);
      check("t6_rst_busy", {31'd0, busy}, 0);
      check("t6_rst_wx", {24'd0, wx}, 0);
      exp_q.delete();
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t6_idle_after", {31'd0, cmd_ready}, 1);
      check("t6_no_brush", {31'd0, brush}, 0);
      base = wr_count;
      run_cmd(1'b0, 126, 1, 4, 2, 1'b0, cyc);
      check("t6_restamp_writes", wr_count - base, 16);
      check("t6_restamp_cycles", cyc, 26);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
